decode_ctrl_pipe: RTL and testbench
===================================

# decode_ctrl_pipe

Registered decode-stage control unit for the MIPS-32 pipeline. It converts a fetched instruction into the 12-bit main control bundle and registers it at the ID/EX boundary, with a valid/ready handshake, stall and flush. It also flags reserved instructions and sequences a multi-cycle HI/LO multiply/divide unit, holding back HI/LO-dependent instructions while that unit is busy.

## Interface
Parameters:
- MUL_LAT, 2: cycles MULT/MULTU occupy the MDU (>=1)
- DIV_LAT, 32: cycles DIV/DIVU occupy the MDU (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  fetch stage presents an instruction
- instr  in  32  instruction word
- instr_ready  out  1  instruction accepted this cycle (combinational)
- stall_in  in  1  downstream stall; hold outputs
- flush  in  1  kill the registered output and refuse input
- ctrl_valid  out  1  ctrl/ri_exc hold a live instruction
- ctrl  out  12  {memtoreg,memen,memwrite,branch,alusrc,regdst,regwrite,hilowrite,jump,jal,jr,bal}
- ri_exc  out  1  reserved instruction; qualifies ctrl_valid
- md_start  out  1  one-cycle MDU start pulse, aligned with ctrl_valid
- md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with md_start
- md_busy  out  1  MDU occupied

## Operation
- Decode classes. Only listed bits are set; all other bits are 0.
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI: alusrc, regwrite.
  - LB/LBU/LH/LHU/LW: memtoreg, memen, alusrc, regwrite.
  - SB/SH/SW: memen, memwrite, alusrc.
  - BEQ/BNE/BGTZ/BLEZ and REGIMM BLTZ/BGEZ: branch.
  - REGIMM BLTZAL/BGEZAL: branch, regwrite, bal.
  - J: jump. JAL: regwrite, jump, jal.
  - SPECIAL (op=0):
    - AND/OR/XOR/NOR, shifts (incl. variable shifts), ADD/ADDU/SUB/SUBU/SLT/SLTU, MFHI/MFLO: regdst, regwrite.
    - MTHI/MTLO/MULT/MULTU/DIV/DIVU: regdst, hilowrite.
    - JR: jump, jr. JALR: regdst, regwrite, jump, jr.
- Funct is decoded only when op=0. REGIMM is decoded by rt only.
- Any other op, funct or REGIMM rt: ctrl=0, ri_exc=1, and the instruction is still accepted with ctrl_valid=1.
- hilo_use(instr) = MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI or MTLO.
- instr_ready = !flush && !stall_in && !(md_busy && hilo_use(instr)).
- Output register update, in priority order on each clock edge:
  1. flush: ctrl_valid, ctrl, ri_exc, md_start all cleared.
  2. stall_in: all outputs hold.
  3. instr_valid && instr_ready: load the decode, ctrl_valid=1; md_start=1 for mult/div.
  4. Otherwise: insert a bubble (ctrl_valid=0, ctrl=0, ri_exc=0, md_start=0).
- MDU FSM, states IDLE and RUN:
  - IDLE→RUN on acceptance of a mult/div. The counter loads LAT-1, where LAT is MUL_LAT for MULT/MULTU and DIV_LAT for DIV/DIVU.
  - In RUN the counter decrements each cycle, including cycles with stall_in high. RUN→IDLE on the edge where the counter is 0.
  - md_busy = (state==RUN).
  - Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).
- A flush does not abort the MDU: RUN continues to completion.
- A second mult/div cannot be accepted while md_busy, because hilo_use blocks it.

## Timing
- Reset values: ctrl_valid=0, ctrl=0, ri_exc=0, md_start=0, md_op=00, md_busy=0, state IDLE, counter 0.
- Decode latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N.
- md_busy rises together with md_start and stays high for exactly LAT cycles.
- A HI/LO instruction presented during RUN gets instr_ready=0. It is accepted in the first cycle after md_busy falls.
- Simultaneous flush and instr_valid: the instruction is not accepted; fetch must re-present it.
- Asserting rst mid-RUN returns the FSM to IDLE immediately and clears md_busy.

## Configuration
- MDU_EN defined:
  - MULT/MULTU/DIV/DIVU decode as above.
  - The FSM, counter, md_start, md_op and md_busy are implemented.
- MDU_EN undefined:
  - MULT/MULTU/DIV/DIVU decode as reserved (ri_exc=1, ctrl=0).
  - md_start, md_op and md_busy are tied to 0, with no FSM or counter.
  - MUL_LAT and DIV_LAT are ignored.
  - MFHI/MFLO/MTHI/MTLO still decode normally and are never stalled.

## Test plan
- Reset, then LW 0x8C220004 with valid -> next cycle ctrl=12'b110010100000, ctrl_valid=1, ri_exc=0.
- JR $31 (0x03E00008), then op=0x3F -> ctrl=12'b000000001010; then ctrl=0 with ri_exc=1 and ctrl_valid=1.
- DIV with DIV_LAT=32, then MFLO presented immediately -> md_start=1, md_op=10; md_busy high for 32 cycles; instr_ready=0 for MFLO until md_busy falls, bubbles emitted; ADDU is accepted during RUN.
- stall_in held 3 cycles with an ORI in the output register -> outputs hold, instr_ready=0; flush in the 4th cycle -> ctrl_valid=0 next cycle.
- MULT with MUL_LAT=1 and rst pulsed during a DIV RUN -> MULT: md_busy high exactly 1 cycle. DIV: md_busy=0 and all outputs at reset values asynchronously.
- Build without MDU_EN, issue MULTU -> ri_exc=1, md_start=0, md_busy stays 0.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: MIPS-32 ID-stage main control decode registered at the ID/EX boundary.
// Optional HI/LO multiply/divide sequencer is built when MDU_EN is defined.
module decode_ctrl_pipe #(
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic        stall_in,
   input  logic        flush,
   output logic        ctrl_valid,
   output logic [11:0] ctrl,
   output logic        ri_exc,
   output logic        md_start,
   output logic [1:0]  md_op,
   output logic        md_busy
);

   localparam logic [11:0] C_MEMTOREG  = 12'b1000_0000_0000;
   localparam logic [11:0] C_MEMEN     = 12'b0100_0000_0000;
   localparam logic [11:0] C_MEMWRITE  = 12'b0010_0000_0000;
   localparam logic [11:0] C_BRANCH    = 12'b0001_0000_0000;
   localparam logic [11:0] C_ALUSRC    = 12'b0000_1000_0000;
   localparam logic [11:0] C_REGDST    = 12'b0000_0100_0000;
   localparam logic [11:0] C_REGWRITE  = 12'b0000_0010_0000;
   localparam logic [11:0] C_HILOWRITE = 12'b0000_0001_0000;
   localparam logic [11:0] C_JUMP      = 12'b0000_0000_1000;
   localparam logic [11:0] C_JAL       = 12'b0000_0000_0100;
   localparam logic [11:0] C_JR        = 12'b0000_0000_0010;
   localparam logic [11:0] C_BAL       = 12'b0000_0000_0001;

   // Returns {ri, ctrl}; unknown op/funct/rt yield ctrl=0 with ri set.
   function automatic logic [12:0] decode_f(input logic [31:0] ins);
      logic [11:0] c;
      logic        ri;
      c  = 12'b0;
      ri = 1'b0;
      case (ins[31:26])
         6'h00: begin
            case (ins[5:0])
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B: c = C_REGDST | C_REGWRITE;
               6'h11, 6'h13: c = C_REGDST | C_HILOWRITE;
`ifdef MDU_EN
               6'h18, 6'h19, 6'h1A, 6'h1B: c = C_REGDST | C_HILOWRITE;
`endif
               6'h08: c = C_JUMP | C_JR;
               6'h09: c = C_REGDST | C_REGWRITE | C_JUMP | C_JR;
               default: ri = 1'b1;
            endcase
         end
         6'h01: begin
            case (ins[20:16])
               5'h00, 5'h01: c = C_BRANCH;
               5'h10, 5'h11: c = C_BRANCH | C_REGWRITE | C_BAL;
               default: ri = 1'b1;
            endcase
         end
         6'h02: c = C_JUMP;
         6'h03: c = C_REGWRITE | C_JUMP | C_JAL;
         6'h04, 6'h05, 6'h06, 6'h07: c = C_BRANCH;
         6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h0C, 6'h0D, 6'h0E, 6'h0F: c = C_ALUSRC | C_REGWRITE;
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c = C_MEMTOREG | C_MEMEN | C_ALUSRC | C_REGWRITE;
         6'h28, 6'h29, 6'h2B: c = C_MEMEN | C_MEMWRITE | C_ALUSRC;
         default: ri = 1'b1;
      endcase
      return {ri, c};
   endfunction

   // MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
   function automatic logic hilo_use_f(input logic [31:0] ins);
      return (ins[31:26] == 6'h00) && ((ins[5:2] == 4'b0100) || (ins[5:2] == 4'b0110));
   endfunction

   function automatic logic is_md_f(input logic [31:0] ins);
      return (ins[31:26] == 6'h00) && (ins[5:2] == 4'b0110);
   endfunction

   logic [12:0] dec_s;
   logic        accept_s;
   logic        md_go_s;
   logic        md_busy_s;
   logic        ctrl_valid_r;
   logic [11:0] ctrl_r;
   logic        ri_exc_r;
   logic        md_start_r;

   assign dec_s       = decode_f(instr);
   assign instr_ready = !flush && !stall_in && !(md_busy_s && hilo_use_f(instr));
   assign accept_s    = instr_valid && instr_ready;

   // ID/EX output register: flush beats stall beats load; otherwise a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_valid_r <= 1'b0;
         ctrl_r       <= 12'b0;
         ri_exc_r     <= 1'b0;
         md_start_r   <= 1'b0;
      end else if (flush) begin
         ctrl_valid_r <= 1'b0;
         ctrl_r       <= 12'b0;
         ri_exc_r     <= 1'b0;
         md_start_r   <= 1'b0;
      end else if (stall_in) begin
         ctrl_valid_r <= ctrl_valid_r;
         ctrl_r       <= ctrl_r;
         ri_exc_r     <= ri_exc_r;
         md_start_r   <= md_start_r;
      end else if (accept_s) begin
         ctrl_valid_r <= 1'b1;
         ctrl_r       <= dec_s[11:0];
         ri_exc_r     <= dec_s[12];
         md_start_r   <= md_go_s;
      end else begin
         ctrl_valid_r <= 1'b0;
         ctrl_r       <= 12'b0;
         ri_exc_r     <= 1'b0;
         md_start_r   <= 1'b0;
      end
   end

   assign ctrl_valid = ctrl_valid_r;
   assign ctrl       = ctrl_r;
   assign ri_exc     = ri_exc_r;
   assign md_start   = md_start_r;

`ifdef MDU_EN
   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_t;

   md_state_t     state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic [1:0]    md_op_r;

   assign md_go_s = accept_s && is_md_f(instr);

   // MDU sequencer next state; flush and stall never interrupt a run
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (md_go_s) begin
               state_nxt_s = RUN;
               cnt_nxt_s   = instr[1] ? DIV_LOAD : MUL_LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CW'(0)) begin
               state_nxt_s = IDLE;
            end else begin
               cnt_nxt_s = cnt_r - CW'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CW'(0);
         end
      endcase
   end

   // MDU state, counter and operation register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= CW'(0);
         md_op_r <= 2'b00;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (md_go_s) begin
            md_op_r <= instr[1:0];
         end
      end
   end

   assign md_busy_s = (state_r == RUN);
   assign md_op     = md_op_r;
   assign md_busy   = md_busy_s;
`else
   // Latency parameters only shape the MDU; keep them referenced for a legality check.
   if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
   end

   assign md_go_s   = 1'b0;
   assign md_busy_s = 1'b0;
   assign md_op     = 2'b00;
   assign md_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe (MUL_LAT=1, DIV_LAT=32); adapts to MDU_EN.
module tb_decode_ctrl_pipe;

`ifdef MDU_EN
   localparam bit MDU = 1'b1;
`else
   localparam bit MDU = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        instr_ready;
   logic        stall_in = 1'b0;
   logic        flush = 1'b0;
   logic        ctrl_valid;
   logic [11:0] ctrl;
   logic        ri_exc;
   logic        md_start;
   logic [1:0]  md_op;
   logic        md_busy;

   decode_ctrl_pipe #(.MUL_LAT(1), .DIV_LAT(32)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .stall_in(stall_in), .flush(flush),
      .ctrl_valid(ctrl_valid), .ctrl(ctrl), .ri_exc(ri_exc),
      .md_start(md_start), .md_op(md_op), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      logic [11:0] ctl;
      logic        ri;
      logic        md;
      logic        hilo;
   } ent_t;

   typedef struct packed {
      logic        v;
      logic [11:0] c;
      logic        ri;
      logic        st;
      logic [1:0]  op;
      logic        busy;
   } exp_t;

   localparam int LW = 0, JR = 1, BAD_OP = 2, ORI = 3, ADDU = 4, DIV = 5, MFLO = 6,
                  MULT = 7, MULTU = 8, MTHI = 16;

   ent_t tbl [22];
   exp_t q [$];
   int   total = 0;
   int   bad = 0;

   logic        m_v = 1'b0, m_ri = 1'b0, m_st = 1'b0;
   logic [11:0] m_c = 12'h000;
   logic [1:0]  m_op = 2'b00;
   int          m_busy_cnt = 0;
   bit          last_acc = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic step(input int idx, input bit v, input bit st, input bit fl);
      ent_t e;
      exp_t x;
      logic [11:0] c;
      logic r;
      bit md, rdy;
      e   = tbl[idx];
      md  = e.md && MDU;
      c   = (e.md && !MDU) ? 12'h000 : e.ctl;
      r   = (e.md && !MDU) ? 1'b1 : e.ri;
      rdy = !fl && !st && !(m_busy_cnt > 0 && e.hilo);
      instr_valid = v;
      instr       = e.ins;
      stall_in    = st;
      flush       = fl;
      #4;
      chk("instr_ready", {31'b0, instr_ready}, {31'b0, rdy});
      last_acc = v && rdy;
      if (fl) begin
         m_v = 1'b0; m_c = 12'h000; m_ri = 1'b0; m_st = 1'b0;
      end else if (st) begin
         m_v = m_v;
      end else if (last_acc) begin
         m_v = 1'b1; m_c = c; m_ri = r; m_st = md;
         if (md) m_op = e.ins[1:0];
      end else begin
         m_v = 1'b0; m_c = 12'h000; m_ri = 1'b0; m_st = 1'b0;
      end
      if (m_busy_cnt > 0) m_busy_cnt--;
      else if (last_acc && md) m_busy_cnt = e.ins[1] ? 32 : 1;
      q.push_back('{m_v, m_c, m_ri, m_st, m_op, (m_busy_cnt > 0)});
      @(posedge clk);
      #1;
      x = q.pop_front();
      chk("ctrl_valid", {31'b0, ctrl_valid}, {31'b0, x.v});
      chk("ctrl", {20'b0, ctrl}, {20'b0, x.c});
      chk("ri_exc", {31'b0, ri_exc}, {31'b0, x.ri});
      chk("md_start", {31'b0, md_start}, {31'b0, x.st});
      chk("md_op", {30'b0, md_op}, {30'b0, x.op});
      chk("md_busy", {31'b0, md_busy}, {31'b0, x.busy});
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, {31'b0, ctrl_valid}, 32'd0);
      chk({tag, "_ctrl"}, {20'b0, ctrl}, 32'd0);
      chk({tag, "_ri"}, {31'b0, ri_exc}, 32'd0);
      chk({tag, "_start"}, {31'b0, md_start}, 32'd0);
      chk({tag, "_op"}, {30'b0, md_op}, 32'd0);
      chk({tag, "_busy"}, {31'b0, md_busy}, 32'd0);
   endtask

   initial begin
      tbl[0]  = '{32'h8C220004, 12'hCA0, 1'b0, 1'b0, 1'b0}; // LW
      tbl[1]  = '{32'h03E00008, 12'h00A, 1'b0, 1'b0, 1'b0}; // JR $31
      tbl[2]  = '{32'hFC000000, 12'h000, 1'b1, 1'b0, 1'b0}; // op 0x3F
      tbl[3]  = '{32'h34210005, 12'h0A0, 1'b0, 1'b0, 1'b0}; // ORI
      tbl[4]  = '{32'h00221821, 12'h060, 1'b0, 1'b0, 1'b0}; // ADDU
      tbl[5]  = '{32'h0022001A, 12'h050, 1'b0, 1'b1, 1'b1}; // DIV
      tbl[6]  = '{32'h00001812, 12'h060, 1'b0, 1'b0, 1'b1}; // MFLO
      tbl[7]  = '{32'h00220018, 12'h050, 1'b0, 1'b1, 1'b1}; // MULT
      tbl[8]  = '{32'h00220019, 12'h050, 1'b0, 1'b1, 1'b1}; // MULTU
      tbl[9]  = '{32'hAC220008, 12'h680, 1'b0, 1'b0, 1'b0}; // SW
      tbl[10] = '{32'h10220003, 12'h100, 1'b0, 1'b0, 1'b0}; // BEQ
      tbl[11] = '{32'h04310004, 12'h121, 1'b0, 1'b0, 1'b0}; // BGEZAL
      tbl[12] = '{32'h0C000010, 12'h02C, 1'b0, 1'b0, 1'b0}; // JAL
      tbl[13] = '{32'h0020F809, 12'h06A, 1'b0, 1'b0, 1'b0}; // JALR
      tbl[14] = '{32'h04250000, 12'h000, 1'b1, 1'b0, 1'b0}; // REGIMM rt=5
      tbl[15] = '{32'h00000001, 12'h000, 1'b1, 1'b0, 1'b0}; // funct 0x01
      tbl[16] = '{32'h00200011, 12'h050, 1'b0, 1'b0, 1'b1}; // MTHI
      tbl[17] = '{32'h3C011234, 12'h0A0, 1'b0, 1'b0, 1'b0}; // LUI
      tbl[18] = '{32'h08000010, 12'h008, 1'b0, 1'b0, 1'b0}; // J
      tbl[19] = '{32'h04200002, 12'h100, 1'b0, 1'b0, 1'b0}; // BLTZ
      tbl[20] = '{32'h00000000, 12'h060, 1'b0, 1'b0, 1'b0}; // SLL nop
      tbl[21] = '{32'h90220000, 12'hCA0, 1'b0, 1'b0, 1'b0}; // LBU

      #2;
      chk_reset_vals("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      step(LW, 1'b1, 1'b0, 1'b0);
      step(JR, 1'b1, 1'b0, 1'b0);
      step(BAD_OP, 1'b1, 1'b0, 1'b0);
      for (int i = 9; i <= 21; i++) step(i, 1'b1, 1'b0, 1'b0);
      step(ADDU, 1'b0, 1'b0, 1'b0);

      // stall holds an ORI for three cycles, then flush kills it
      step(ORI, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(ADDU, 1'b1, 1'b1, 1'b0);
      step(ADDU, 1'b1, 1'b0, 1'b1);
      step(ADDU, 1'b0, 1'b0, 1'b0);

      // DIV then MFLO blocked until the MDU drains; ADDU slips in during the run
      step(DIV, 1'b1, 1'b0, 1'b0);
      step(ADDU, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(MFLO, 1'b1, 1'b0, 1'b0);
         if (last_acc) break;
      end
      chk("mflo_accepted", {31'b0, last_acc}, 32'd1);

      // one-cycle MULT then dependent MTHI
      step(MULT, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(MTHI, 1'b1, 1'b0, 1'b0);
         if (last_acc) break;
      end
      chk("mthi_accepted", {31'b0, last_acc}, 32'd1);
      step(MULTU, 1'b1, 1'b0, 1'b0);
      step(ADDU, 1'b0, 1'b0, 1'b0);
      step(ADDU, 1'b0, 1'b0, 1'b0);

      // flush does not abort a DIV; async reset does
      step(DIV, 1'b1, 1'b0, 1'b0);
      step(ADDU, 1'b1, 1'b0, 1'b1);
      step(ADDU, 1'b1, 1'b0, 1'b0);
      step(MFLO, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk_reset_vals("midrun_rst");
      m_v = 1'b0; m_c = 12'h000; m_ri = 1'b0; m_st = 1'b0; m_op = 2'b00; m_busy_cnt = 0;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(MFLO, 1'b1, 1'b0, 1'b0);
      step(LW, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
